// File: rtl/fir_pkg.sv
// Shared types and default sizing for the FIR coefficient loader.
package fir_pkg;

    // Loader states: waiting for a set, filling the shadow bank, holding a
    // complete set until the next sample boundary, and discarding an overlong set.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ARMED = 2'd2,
        DRAIN = 2'd3
    } fir_state_e;

    localparam int FIR_WIDTH = 16;
    localparam int FIR_TAPS  = 8;

    // Width of an index that spans 0..taps-1 (at least one bit).
    function automatic int idx_width(input int taps);
        return (taps > 1) ? $clog2(taps) : 1;
    endfunction

    localparam int FIR_IDX_W = idx_width(FIR_TAPS);

endpackage

// File: rtl/fir_coeff_bank.sv
// Shadow and active coefficient registers. The shadow bank is filled one word
// at a time; a commit copies the entire shadow bank into the active bank in a
// single edge so the tap chain never observes a partial update.
module fir_coeff_bank
    import fir_pkg::*;
#(
    parameter int WIDTH = FIR_WIDTH,
    parameter int TAPS  = FIR_TAPS,
    parameter int IDX_W = FIR_IDX_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [IDX_W-1:0]        wr_idx,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic                    commit,
    output logic [TAPS*WIDTH-1:0]   coeff_flat
);

    logic [WIDTH-1:0] shadow [TAPS];
    logic [WIDTH-1:0] active [TAPS];

    // Shadow bank: one entry written per accepted word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) begin
                shadow[k] <= '0;
            end
        end else if (wr_en) begin
            shadow[wr_idx] <= wr_data;
        end
    end

    // Active bank: whole-set copy from the shadow bank on commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) begin
                active[k] <= '0;
            end
        end else if (commit) begin
            for (int k = 0; k < TAPS; k++) begin
                active[k] <= shadow[k];
            end
        end
    end

    for (genvar k = 0; k < TAPS; k++) begin : g_flat
        assign coeff_flat[k*WIDTH +: WIDTH] = active[k];
    end

endmodule

// File: rtl/fir_coeff_loader.sv
// Coefficient loader: accepts a set of TAPS words into a shadow bank and
// commits it to the active bank on the first sample boundary after the set
// completes. Malformed sets (too short or too long) raise load_err and leave
// the active bank untouched.
module fir_coeff_loader
    import fir_pkg::*;
#(
    parameter int WIDTH = FIR_WIDTH,
    parameter int TAPS  = FIR_TAPS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [WIDTH-1:0]        s_data,
    input  logic                    s_last,
    input  logic                    sample_en,
    output logic [TAPS*WIDTH-1:0]   coeff_flat,
    output logic                    coeff_update,
    output logic                    load_err,
    output logic                    busy
);

    localparam int IDX_W = idx_width(TAPS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS - 1);

    fir_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             update_q, update_d;
    logic             err_q, err_d;
    logic             wr_en;
    logic             commit;
    logic             xfer;

    // Handshake: a word moves on a rising edge where s_valid && s_ready.
    // s_ready depends only on state (low only while a complete set waits for
    // its sample boundary), never on s_valid; s_data/s_last are ignored
    // unless a transfer happens.
    assign s_ready = (state_q != ARMED);
    assign busy    = (state_q != IDLE);
    assign xfer    = s_valid && s_ready;

    // State, write index and registered one-cycle pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            update_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            update_q <= update_d;
            err_q    <= err_d;
        end
    end

    // Next-state, index and strobe decode.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        wr_en    = 1'b0;
        commit   = 1'b0;
        update_d = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    wr_en = 1'b1;
                    if (s_last) begin
                        err_d = 1'b1;
                    end else begin
                        idx_d   = IDX_W'(1);
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (xfer) begin
                    wr_en = 1'b1;
                    if (s_last) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = ARMED;
                        end else begin
                            err_d   = 1'b1;
                            idx_d   = '0;
                            state_d = IDLE;
                        end
                    end else if (idx_q == LAST_IDX) begin
                        err_d   = 1'b1;
                        idx_d   = '0;
                        state_d = DRAIN;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ARMED: begin
                if (sample_en) begin
                    commit   = 1'b1;
                    update_d = 1'b1;
                    idx_d    = '0;
                    state_d  = IDLE;
                end
            end
            DRAIN: begin
                if (xfer && s_last) begin
                    state_d = IDLE;
                end
            end
            default: begin
                idx_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign coeff_update = update_q;
    assign load_err     = err_q;

    fir_coeff_bank #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .IDX_W (IDX_W)
    ) u_bank (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_idx     (idx_q),
        .wr_data    (s_data),
        .commit     (commit),
        .coeff_flat (coeff_flat)
    );

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Bench for fir_coeff_loader: drivers push expected commits and error pulses
// into queues; a negedge monitor pops them when the DUT pulses and tracks the
// expected active bank every cycle.
module tb_fir_coeff_loader;

    localparam int W    = 16;
    localparam int TAPS = 8;
    localparam int FW   = W * TAPS;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [W-1:0]  s_data = '0;
    logic          s_last = 1'b0;
    logic          sample_en = 1'b0;
    logic [FW-1:0] coeff_flat;
    logic          coeff_update;
    logic          load_err;
    logic          busy;

    int total = 0;
    int bad   = 0;

    logic [FW-1:0] exp_q[$];
    int            err_q[$];
    logic [FW-1:0] cur_active = '0;
    logic [FW-1:0] last_flat  = '0;

    always #5 clk = ~clk;

    fir_coeff_loader #(.WIDTH(W), .TAPS(TAPS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .s_last       (s_last),
        .sample_en    (sample_en),
        .coeff_flat   (coeff_flat),
        .coeff_update (coeff_update),
        .load_err     (load_err),
        .busy         (busy)
    );

    task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: consume expected pulses and compare the active bank each cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (coeff_update !== 1'b0) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL update_unexpected: got coeff_update=%b expected 0", coeff_update);
                    end else begin
                        cur_active = exp_q.pop_front();
                    end
                end
                if (load_err !== 1'b0) begin
                    total++;
                    if (err_q.size() == 0) begin
                        bad++;
                        $display("FAIL err_unexpected: got load_err=%b expected 0", load_err);
                    end else begin
                        void'(err_q.pop_front());
                    end
                end
                check("coeff_flat", coeff_flat, cur_active);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog");
    end

    task automatic idle_cycle(input bit rand_se);
        s_valid   = 1'b0;
        s_data    = W'($urandom);
        s_last    = 1'($urandom_range(0, 1));
        sample_en = rand_se ? 1'($urandom_range(0, 1)) : 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic send_word(input logic [W-1:0] d, input logic l);
        int  guard;
        bit  acc;
        guard   = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        forever begin
            acc = s_ready;
            @(posedge clk); #1;
            if (acc) break;
            guard++;
            if (guard > 100) begin
                total++;
                bad++;
                $display("FAIL ready_timeout: got s_ready=0 expected 1 within 100 cycles");
                break;
            end
        end
        s_valid = 1'b0;
        s_data  = W'($urandom);
        s_last  = 1'($urandom_range(0, 1));
    endtask

    // Send an n-word set with s_last on word n; the model decides its fate.
    task automatic send_set(input int n, input bit gaps, input bit se_on_last, input bit seq_data);
        logic [FW-1:0] flat;
        logic [W-1:0]  d;
        flat = '0;
        if (n != TAPS) err_q.push_back(n);
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) idle_cycle(1'b1);
            d = seq_data ? W'(i + 1) : W'($urandom);
            if (i < TAPS) flat[i*W +: W] = d;
            if (i == n - 1) sample_en = se_on_last;
            else sample_en = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
            send_word(d, (i == n - 1));
        end
        sample_en = 1'b0;
        if (n == TAPS) begin
            exp_q.push_back(flat);
            last_flat = flat;
        end
    endtask

    task automatic pulse_sample();
        sample_en = 1'b1;
        @(posedge clk); #1;
        sample_en = 1'b0;
    endtask

    task automatic settle();
        repeat (2) @(posedge clk);
        #1;
        check("err_q_drained", FW'(err_q.size()), '0);
        check("exp_q_drained", FW'(exp_q.size()), '0);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        s_valid   = 1'b0;
        sample_en = 1'b0;
        exp_q.delete();
        err_q.delete();
        cur_active = '0;
        @(negedge clk);
        check("rst_coeff_flat", coeff_flat, '0);
        check("rst_coeff_update", FW'(coeff_update), '0);
        check("rst_load_err", FW'(load_err), '0);
        check("rst_busy", FW'(busy), '0);
        check("rst_s_ready", FW'(s_ready), FW'(1));
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [FW-1:0] seq_flat;
        int            n;
        seq_flat = '0;
        for (int k = 0; k < TAPS; k++) seq_flat[k*W +: W] = W'(k + 1);

        do_reset();
        @(posedge clk); #1;

        // Back-to-back set 1..8, commit three cycles after the last word.
        send_set(TAPS, 1'b0, 1'b0, 1'b1);
        check("armed_s_ready", FW'(s_ready), '0);
        check("armed_busy", FW'(busy), FW'(1));
        check("armed_flat_old", coeff_flat, '0);
        idle_cycle(1'b0);
        idle_cycle(1'b0);
        check("armed_s_ready_wait", FW'(s_ready), '0);
        pulse_sample();
        check("commit_update", FW'(coeff_update), FW'(1));
        check("commit_flat", coeff_flat, seq_flat);
        check("commit_s_ready", FW'(s_ready), FW'(1));
        check("commit_busy", FW'(busy), '0);
        idle_cycle(1'b0);
        check("update_one_cycle", FW'(coeff_update), '0);
        settle();

        // sample_en on the last-word edge does not commit; next edge does.
        send_set(TAPS, 1'b0, 1'b1, 1'b0);
        check("no_commit_on_last", FW'(coeff_update), '0);
        check("no_commit_s_ready", FW'(s_ready), '0);
        sample_en = 1'b1;
        @(posedge clk); #1;
        sample_en = 1'b0;
        check("commit_next_edge", FW'(coeff_update), FW'(1));
        check("commit_next_flat", coeff_flat, last_flat);
        settle();

        // Short set: error, back to IDLE, then a good set loads.
        send_set(5, 1'b0, 1'b0, 1'b0);
        settle();
        check("short_busy", FW'(busy), '0);
        check("short_s_ready", FW'(s_ready), FW'(1));
        send_set(TAPS, 1'b0, 1'b0, 1'b0);
        pulse_sample();
        settle();

        // Long set: error after word 8, rest drained, no commit.
        send_set(TAPS + 2, 1'b0, 1'b0, 1'b0);
        check("long_busy_after", FW'(busy), '0);
        pulse_sample();
        check("long_no_update", FW'(coeff_update), '0);
        settle();

        // Randomized sets with gaps, random lengths and random strobes.
        for (int s = 0; s < 12; s++) begin
            case ($urandom_range(0, 3))
                0:       n = $urandom_range(1, TAPS - 1);
                1:       n = $urandom_range(TAPS + 1, TAPS + 3);
                default: n = TAPS;
            endcase
            send_set(n, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
            if (n == TAPS) repeat ($urandom_range(0, 3)) idle_cycle(1'b0);
            pulse_sample();
            settle();
        end

        // Reset mid-load after a committed set, then reset while ARMED.
        send_set(TAPS, 1'b0, 1'b0, 1'b0);
        pulse_sample();
        settle();
        for (int i = 0; i < 4; i++) send_word(W'($urandom), 1'b0);
        do_reset();
        check("post_rst_flat", coeff_flat, '0);
        send_set(TAPS, 1'b0, 1'b0, 1'b0);
        do_reset();
        send_set(TAPS, 1'b1, 1'b0, 1'b0);
        pulse_sample();
        check("post_rst_commit", coeff_flat, last_flat);
        settle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
